// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution loop controller.
package conv_ctrl_pkg;

    localparam int unsigned TAP_IDX_W = 16;

    typedef enum logic [2:0] {IDLE, LOAD_W, MAC, DRAIN, DONE} fsm_state_t;

    typedef logic [31:0] coord_t;

    // Untruncated partial-sum address; callers cut it to the memory address width.
    function automatic logic [63:0] psum_addr(input coord_t x, input coord_t y, input coord_t ch,
                                              input int unsigned width,
                                              input int unsigned nb_ch);
        return ((64'(y) * 64'(width)) + 64'(x)) * 64'(nb_ch) + 64'(ch);
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Resettable fixed-latency shift register carrying write-back strobes, coordinates and address.
module ctrl_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/conv_loop_controller.sv
// Convolution loop sequencer: ch_in/ch_out/y/x/ky/kx walk, operand handshake and MAC/psum strobes.
// Optional feature: define CONV_ZERO_PAD_EN to generate padding taps internally.
module conv_loop_controller
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned LOG2_OF_MEM_HEIGHT = 20,
    parameter int unsigned FEATURE_MAP_WIDTH  = 64,
    parameter int unsigned FEATURE_MAP_HEIGHT = 64,
    parameter int unsigned INPUT_NB_CHANNELS  = 32,
    parameter int unsigned OUTPUT_NB_CHANNELS = 32,
    parameter int unsigned KERNEL_SIZE        = 3,
    parameter int unsigned MAC_PIPE_DEPTH     = 5
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    output logic                          running,
    output logic                          done,
    input  logic                          valid,
    output logic                          ready,
    output logic                          write_w,
    output logic [TAP_IDX_W-1:0]          w_idx,
    output logic                          write_a,
    output logic                          mac_valid,
    output logic                          mac_zero,
    output logic                          mac_accumulate_with_0,
    output logic                          mem_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
    output logic                          mem_we,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
    output logic                          output_valid,
    output logic [31:0]                   output_x,
    output logic [31:0]                   output_y,
    output logic [31:0]                   output_ch
);

    localparam int unsigned KK   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned AW   = LOG2_OF_MEM_HEIGHT;
    localparam int unsigned DL_W = 2 + 3 * 32 + AW;

    fsm_state_t           state;
    coord_t               ci, co, y, x, ky, kx;
    logic [TAP_IDX_W-1:0] w_cnt;
    logic [31:0]          drain_cnt;
    logic                 is_pad, tap_first, tap_last, pair_last, fire_last;
    logic [AW-1:0]        cur_addr;
    logic [DL_W-1:0]      dl_in, dl_out;

`ifdef CONV_ZERO_PAD_EN
    localparam int unsigned PAD = (KERNEL_SIZE - 1) / 2;
    // Unsigned form of "y+ky-P outside [0,H)" avoids negative intermediates.
    assign is_pad = (y + ky < PAD) || (y + ky >= FEATURE_MAP_HEIGHT + PAD) ||
                    (x + kx < PAD) || (x + kx >= FEATURE_MAP_WIDTH + PAD);
`else
    assign is_pad = 1'b0;
`endif

    assign tap_first = (ky == '0) && (kx == '0);
    assign tap_last  = (ky == KERNEL_SIZE - 1) && (kx == KERNEL_SIZE - 1);
    assign pair_last = (ci == INPUT_NB_CHANNELS - 1) && (co == OUTPUT_NB_CHANNELS - 1);

    assign running   = (state != IDLE);
    assign done      = (state == DONE);
    assign w_idx     = w_cnt;
    assign ready     = (state == LOAD_W) || ((state == MAC) && !is_pad);
    assign write_w   = (state == LOAD_W) && valid;
    assign write_a   = (state == MAC) && !is_pad && valid;
    assign mac_valid = (state == MAC) && (is_pad || valid);
    assign mac_zero  = mac_valid && is_pad;

    assign mac_accumulate_with_0 = mac_valid && tap_first && (ci == '0);
    assign mem_re                = mac_valid && tap_first && (ci != '0);

    assign cur_addr      = AW'(psum_addr(x, y, co, FEATURE_MAP_WIDTH, OUTPUT_NB_CHANNELS));
    assign mem_read_addr = mem_re ? cur_addr : '0;

    // Payload is zeroed when idle so that all outputs rest at 0 between strobes.
    assign fire_last = mac_valid && tap_last;
    assign dl_in     = fire_last ? {ci != INPUT_NB_CHANNELS - 1, ci == INPUT_NB_CHANNELS - 1,
                                    x, y, co, cur_addr} : '0;

    ctrl_delay_line #(
        .WIDTH(DL_W),
        .DEPTH(MAC_PIPE_DEPTH)
    ) u_delay (
        .clk  (clk),
        .rst_n(arst_n_in),
        .din  (dl_in),
        .dout (dl_out)
    );

    assign {mem_we, output_valid, output_x, output_y, output_ch, mem_write_addr} = dl_out;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state     <= IDLE;
            ci        <= '0;
            co        <= '0;
            y         <= '0;
            x         <= '0;
            ky        <= '0;
            kx        <= '0;
            w_cnt     <= '0;
            drain_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) state <= LOAD_W;
                LOAD_W: begin
                    if (valid) begin
                        if (w_cnt == TAP_IDX_W'(KK - 1)) begin
                            w_cnt <= '0;
                            state <= MAC;
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
                end
                MAC: begin
                    if (mac_valid) begin
                        kx <= kx + 1;
                        if (kx == KERNEL_SIZE - 1) begin
                            kx <= '0;
                            ky <= ky + 1;
                            if (ky == KERNEL_SIZE - 1) begin
                                ky <= '0;
                                x  <= x + 1;
                                if (x == FEATURE_MAP_WIDTH - 1) begin
                                    x <= '0;
                                    y <= y + 1;
                                    if (y == FEATURE_MAP_HEIGHT - 1) begin
                                        y     <= '0;
                                        co    <= co + 1;
                                        state <= pair_last ? DRAIN : LOAD_W;
                                        if (co == OUTPUT_NB_CHANNELS - 1) begin
                                            co <= '0;
                                            ci <= (ci == INPUT_NB_CHANNELS - 1) ? '0 : ci + 1;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == MAC_PIPE_DEPTH - 1) begin
                        drain_cnt <= '0;
                        state     <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_loop_controller.sv
// Bench for conv_loop_controller: operand-stream model, per-cycle compare and literal totals.
module tb_conv_loop_controller;

    localparam int W = 4, H = 4, CI = 2, CO = 2, K = 3, P = 1, DEPTH = 5, AW = 10;
`ifdef CONV_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
    localparam int E_WA = 400, E_MZ = 176;
`else
    localparam bit PAD_EN = 1'b0;
    localparam int E_WA = 576, E_MZ = 0;
`endif

    logic clk, arst_n_in, start, valid;
    logic running, done, ready, write_w, write_a, mac_valid, mac_zero, mac_acc0;
    logic mem_re, mem_we, output_valid;
    logic [15:0] w_idx;
    logic [AW-1:0] mem_read_addr, mem_write_addr;
    logic [31:0] output_x, output_y, output_ch;

    logic s_start, s_valid;
    logic s_running, s_done, s_ready, s_write_w, s_write_a, s_mac_valid, s_mac_zero, s_acc0;
    logic s_mem_re, s_mem_we, s_ov;
    logic [15:0] s_w_idx;
    logic [7:0] s_raddr, s_waddr;
    logic [31:0] s_x, s_y, s_ch;

    conv_loop_controller #(
        .LOG2_OF_MEM_HEIGHT(AW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
        .INPUT_NB_CHANNELS(CI), .OUTPUT_NB_CHANNELS(CO), .KERNEL_SIZE(K), .MAC_PIPE_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running), .done(done),
        .valid(valid), .ready(ready), .write_w(write_w), .w_idx(w_idx), .write_a(write_a),
        .mac_valid(mac_valid), .mac_zero(mac_zero), .mac_accumulate_with_0(mac_acc0),
        .mem_re(mem_re), .mem_read_addr(mem_read_addr), .mem_we(mem_we),
        .mem_write_addr(mem_write_addr), .output_valid(output_valid), .output_x(output_x),
        .output_y(output_y), .output_ch(output_ch)
    );

    conv_loop_controller #(
        .LOG2_OF_MEM_HEIGHT(8), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
        .INPUT_NB_CHANNELS(2), .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(1), .MAC_PIPE_DEPTH(2)
    ) dut_k1 (
        .clk(clk), .arst_n_in(arst_n_in), .start(s_start), .running(s_running), .done(s_done),
        .valid(s_valid), .ready(s_ready), .write_w(s_write_w), .w_idx(s_w_idx),
        .write_a(s_write_a), .mac_valid(s_mac_valid), .mac_zero(s_mac_zero),
        .mac_accumulate_with_0(s_acc0), .mem_re(s_mem_re), .mem_read_addr(s_raddr),
        .mem_we(s_mem_we), .mem_write_addr(s_waddr), .output_valid(s_ov), .output_x(s_x),
        .output_y(s_y), .output_ch(s_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_w; int unsigned idx;
        bit pad, acc0, re, last, we, ov;
        int unsigned raddr, x, y, ch;
    } item_t;
    typedef struct {
        int unsigned due; bit we, ov; int unsigned addr, x, y, ch;
    } wb_t;

    item_t items[$];
    wb_t   wbq[$];
    bit    m_run;
    int unsigned cyc, done_due;
    int unsigned checks, errors;
    int unsigned cnt[7], snap[7];
    int unsigned s_cnt[3], s_snap[3];
    int unsigned re19_cyc, ov121_cyc, addr211;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [127:0] act_flags();
        return 128'({running, done, ready, write_w, write_a, mac_valid, mac_zero, mac_acc0,
                     mem_re, mem_we, output_valid, w_idx});
    endfunction

    function automatic logic [127:0] act_data();
        return 128'({mem_read_addr, mem_write_addr, output_x, output_y, output_ch});
    endfunction

    // Operand consumption order of one layer: K*K weights per pair, then every tap.
    function automatic void build_layer();
        item_t it;
        int r, c;
        for (int ci = 0; ci < CI; ci++)
            for (int co = 0; co < CO; co++) begin
                for (int i = 0; i < K * K; i++) begin
                    it = '{default: 0};
                    it.is_w = 1'b1;
                    it.idx = i;
                    items.push_back(it);
                end
                for (int y = 0; y < H; y++)
                    for (int x = 0; x < W; x++)
                        for (int ky = 0; ky < K; ky++)
                            for (int kx = 0; kx < K; kx++) begin
                                r = y + ky - P;
                                c = x + kx - P;
                                it = '{default: 0};
                                it.pad   = PAD_EN && (r < 0 || r >= H || c < 0 || c >= W);
                                it.acc0  = (ci == 0) && (ky == 0) && (kx == 0);
                                it.re    = (ci != 0) && (ky == 0) && (kx == 0);
                                it.raddr = ((y * W + x) * CO + co) % (1 << AW);
                                it.last  = (ky == K - 1) && (kx == K - 1);
                                it.we    = it.last && (ci != CI - 1);
                                it.ov    = it.last && (ci == CI - 1);
                                it.x = x; it.y = y; it.ch = co;
                                items.push_back(it);
                            end
            end
    endfunction

    function automatic void monitor_cycle();
        bit e_run, e_done, e_rdy, e_ww, e_wa, e_mv, e_mz, e_acc, e_re, e_we, e_ov, fire, st;
        int unsigned e_widx, e_ra, e_wad, e_x, e_y, e_ch;
        item_t h;
        wb_t wb;
        {e_run, e_done, e_rdy, e_ww, e_wa, e_mv, e_mz, e_acc, e_re, e_we, e_ov, fire} = '0;
        {e_widx, e_ra, e_wad, e_x, e_y, e_ch} = '0;
        cyc++;
        if (!arst_n_in) begin
            items.delete();
            wbq.delete();
            m_run = 1'b0;
        end else begin
            st = !m_run && start;
            e_run = m_run;
            if (m_run && items.size() > 0) begin
                h = items[0];
                if (h.is_w) begin
                    e_rdy = 1'b1; e_ww = valid; e_widx = h.idx; fire = valid;
                end else if (h.pad) begin
                    e_mv = 1'b1; e_mz = 1'b1; fire = 1'b1;
                end else begin
                    e_rdy = 1'b1; e_wa = valid; e_mv = valid; fire = valid;
                end
                if (!h.is_w && fire) begin
                    e_acc = h.acc0;
                    e_re  = h.re;
                    e_ra  = h.re ? h.raddr : 0;
                    if (h.last) begin
                        wb = '{due: cyc + DEPTH, we: h.we, ov: h.ov, addr: h.raddr,
                               x: h.x, y: h.y, ch: h.ch};
                        wbq.push_back(wb);
                    end
                end
                if (fire) begin
                    void'(items.pop_front());
                    if (items.size() == 0) done_due = cyc + DEPTH + 1;
                end
            end
            if (wbq.size() > 0 && wbq[0].due == cyc) begin
                e_we = wbq[0].we; e_ov = wbq[0].ov; e_wad = wbq[0].addr;
                e_x = wbq[0].x; e_y = wbq[0].y; e_ch = wbq[0].ch;
                void'(wbq.pop_front());
            end
            if (m_run && items.size() == 0 && cyc == done_due) begin
                e_done = 1'b1;
                m_run = 1'b0;
            end
            if (st) begin
                build_layer();
                m_run = 1'b1;
            end
        end
        check("flags", act_flags(), 128'({e_run, e_done, e_rdy, e_ww, e_wa, e_mv, e_mz, e_acc,
                                          e_re, e_we, e_ov, 16'(e_widx)}));
        check("data", act_data(), 128'({AW'(e_ra), AW'(e_wad), e_x, e_y, e_ch}));
        cnt[0] += write_w; cnt[1] += write_a; cnt[2] += mac_valid; cnt[3] += mac_zero;
        cnt[4] += output_valid; cnt[5] += mem_we; cnt[6] += done;
        s_cnt[0] += s_write_w; s_cnt[1] += s_write_a; s_cnt[2] += s_done;
        if (mem_re && mem_read_addr == AW'(19)) re19_cyc = cyc;
        if (output_valid && output_x == 1 && output_y == 2 && output_ch == 1) ov121_cyc = cyc;
        if (output_valid && output_x == 2 && output_y == 1 && output_ch == 1)
            addr211 = 32'(mem_write_addr);
    endfunction

    task automatic tick();
        @(negedge clk);
        monitor_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_layer(input bit toggle, output int unsigned ncyc);
        int unsigned d0;
        d0 = cnt[6];
        ncyc = 0;
        while (cnt[6] == d0 && ncyc < 5000) begin
            if (toggle) valid = ~valid;
            tick();
            ncyc++;
        end
        check("layer_done_in_budget", 128'(cnt[6] != d0), 128'd1);
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic check_totals(string tag);
        check({tag, "_write_w"}, 128'(cnt[0] - snap[0]), 128'd36);
        check({tag, "_write_a"}, 128'(cnt[1] - snap[1]), 128'(E_WA));
        check({tag, "_mac_valid"}, 128'(cnt[2] - snap[2]), 128'd576);
        check({tag, "_mac_zero"}, 128'(cnt[3] - snap[3]), 128'(E_MZ));
        check({tag, "_output_valid"}, 128'(cnt[4] - snap[4]), 128'd32);
        check({tag, "_mem_we"}, 128'(cnt[5] - snap[5]), 128'd32);
        check({tag, "_done_once"}, 128'(cnt[6] - snap[6]), 128'd1);
    endtask

    initial begin
        int unsigned t_a, t_b, t_c;
        arst_n_in = 1'b0; start = 1'b0; valid = 1'b0; s_start = 1'b0; s_valid = 1'b1;
        tick();
        tick();
        check("reset_flags", act_flags(), 128'd0);
        check("reset_data", act_data(), 128'd0);
        arst_n_in = 1'b1;
        tick();

        // Full layer with valid held high; extra start while running must be ignored.
        valid = 1'b1; snap = cnt; s_snap = s_cnt;
        start = 1'b1; s_start = 1'b1;
        tick();
        start = 1'b0; s_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_layer(1'b0, t_a);
        check_totals("full");
        check("px12_re_to_out_latency", 128'(ov121_cyc - re19_cyc), 128'd13);
        check("px21_ch1_write_addr", 128'(addr211), 128'd13);
        check("k1_weight_beats", 128'(s_cnt[0] - s_snap[0]), 128'd4);
        check("k1_act_beats", 128'(s_cnt[1] - s_snap[1]), 128'd16);
        check("k1_done_once", 128'(s_cnt[2] - s_snap[2]), 128'd1);

        // Same layer with valid toggling every cycle.
        snap = cnt; valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        run_layer(1'b1, t_b);
        check_totals("toggle");
        check("toggle_takes_longer", 128'(t_b > t_a), 128'd1);

        // Asynchronous reset mid-MAC, then a clean restart.
        valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        arst_n_in = 1'b0;
        #1;
        check("midrun_reset_flags", act_flags(), 128'd0);
        check("midrun_reset_data", act_data(), 128'd0);
        tick();
        tick();
        arst_n_in = 1'b1;
        snap = cnt; start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_load_w_idx0", 128'({running, w_idx}), 128'h10000);
        run_layer(1'b0, t_c);
        check_totals("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
